day_calendar: RTL and testbench

- Parametrised day-of-month counter for the century clock.
- Sits between the hour counter (supplies `done_hour`) and the month counter (consumes `done_day`).
- Generalises the fixed day counter with:
  - configurable widths and base year;
  - selectable leap rule;
  - setup inc/dec;
  - automatic clamping when month or year changes;
  - an optional weekday output.

---
 rtl/clock_pkg.sv | 36 +++
 rtl/day_calendar_if.sv | 42 ++++
 rtl/day_calendar_month_len.sv | 28 ++
 rtl/day_calendar.sv | 83 ++++++++
 tb/tb_day_calendar.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared calendar definitions for the century clock: month numbers,
// day-count width, and leap-year / month-length helpers.
package clock_pkg;

    localparam int DAYS_W = 5;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    // mode 0: every fourth year; mode 1: full Gregorian century rule
    function automatic logic is_leap(input int year, input int mode);
        if (mode == 0)
            return (year % 4) == 0;
        return ((year % 4) == 0) && (((year % 100) != 0) || ((year % 400) == 0));
    endfunction

    function automatic logic [DAYS_W-1:0] days_in_month(input logic [3:0] month, input logic leap);
        case (month)
            FEB:                               return leap ? DAYS_W'(29) : DAYS_W'(28);
            APR, JUN, SEP, NOV:                return DAYS_W'(30);
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: return DAYS_W'(31);
            default:                           return DAYS_W'(31);
        endcase
    endfunction

endpackage

// File: rtl/day_calendar_if.sv
// Signal bundle between the day counter and its neighbours (hour counter,
// month/year counters, setup panel). weekday exists only with DAY_OF_WEEK_EN.
interface day_calendar_if
    import clock_pkg::*;
#(
    parameter int DAY_W   = 6,
    parameter int MONTH_W = 6,
    parameter int YEAR_W  = 7
);
    // Pulses (done_hour, set_inc, set_dec, done_day) are single-cycle levels
    // sampled on the rising clock edge; there is no backpressure.
    logic               done_hour;
    logic               setup_day;
    logic               set_inc;
    logic               set_dec;
    logic [MONTH_W-1:0] curr_month;
    logic [YEAR_W-1:0]  curr_year;
    logic [DAY_W-1:0]   day;
    logic               done_day;
    logic [DAYS_W-1:0]  dim;
    logic               month_err;
`ifdef DAY_OF_WEEK_EN
    logic [2:0]         weekday;
`endif

    modport master (
        output done_hour, setup_day, set_inc, set_dec, curr_month, curr_year,
`ifdef DAY_OF_WEEK_EN
        input  weekday,
`endif
        input  day, done_day, dim, month_err
    );

    modport slave (
        input  done_hour, setup_day, set_inc, set_dec, curr_month, curr_year,
`ifdef DAY_OF_WEEK_EN
        output weekday,
`endif
        output day, done_day, dim, month_err
    );

endinterface

// File: rtl/day_calendar_month_len.sv
// Combinational month length: days in the selected month of the selected
// year, with an error flag for out-of-range month numbers.
module month_len
    import clock_pkg::*;
#(
    parameter int MONTH_W   = 6,
    parameter int YEAR_W    = 7,
    parameter int BASE_YEAR = 2000,
    parameter int LEAP_MODE = 1
) (
    input  logic [MONTH_W-1:0] curr_month,
    input  logic [YEAR_W-1:0]  curr_year,
    output logic [DAYS_W-1:0]  dim,
    output logic               month_err
);

    int   full_year;
    logic leap;

    always_comb begin
        full_year = BASE_YEAR + int'(curr_year);
        leap      = is_leap(full_year, LEAP_MODE);
        month_err = (curr_month == '0) || (curr_month > MONTH_W'(12));
        // an invalid month counts as a long month so the day never clamps to junk
        dim       = month_err ? DAYS_W'(31) : days_in_month(curr_month[3:0], leap);
    end

endmodule

// File: rtl/day_calendar.sv
// Day-of-month counter: clamp on month/year change, setup inc/dec, run
// advance with rollover pulse. Optional weekday register under DAY_OF_WEEK_EN.
module day_calendar
    import clock_pkg::*;
#(
    parameter int DAY_W     = 6,
    parameter int MONTH_W   = 6,
    parameter int YEAR_W    = 7,
    parameter int BASE_YEAR = 2000,
    parameter int LEAP_MODE = 1
`ifdef DAY_OF_WEEK_EN
    , parameter int RESET_WEEKDAY = 6
`endif
) (
    input  logic          clk,
    input  logic          rst,
    day_calendar_if.slave bus
);

    localparam logic [DAY_W-1:0] DAY_ONE = DAY_W'(1);

    logic [DAYS_W-1:0] dim;
    logic              month_err;
    logic [DAY_W-1:0]  dim_d;
    logic [DAY_W-1:0]  day_q;
    logic              done_q;
`ifdef DAY_OF_WEEK_EN
    logic [2:0]        wd_q;
`endif

    month_len #(
        .MONTH_W  (MONTH_W),
        .YEAR_W   (YEAR_W),
        .BASE_YEAR(BASE_YEAR),
        .LEAP_MODE(LEAP_MODE)
    ) u_month_len (
        .curr_month(bus.curr_month),
        .curr_year (bus.curr_year),
        .dim       (dim),
        .month_err (month_err)
    );

    assign dim_d         = DAY_W'(dim);
    assign bus.dim       = dim;
    assign bus.month_err = month_err;
    assign bus.day       = day_q;
    assign bus.done_day  = done_q;
`ifdef DAY_OF_WEEK_EN
    assign bus.weekday   = wd_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            day_q  <= DAY_ONE;
            done_q <= 1'b0;
`ifdef DAY_OF_WEEK_EN
            wd_q   <= 3'(RESET_WEEKDAY);
`endif
        end else begin
            done_q <= 1'b0;
            // a shorter month/year took effect: pull the day back first, ignore everything else
            if (day_q > dim_d) begin
                day_q <= dim_d;
            end else if (bus.setup_day) begin
                if (bus.set_inc && !bus.set_dec)
                    day_q <= (day_q == dim_d) ? DAY_ONE : day_q + DAY_ONE;
                else if (bus.set_dec && !bus.set_inc)
                    day_q <= (day_q == DAY_ONE) ? dim_d : day_q - DAY_ONE;
            end else if (bus.done_hour) begin
                if (day_q == dim_d) begin
                    day_q  <= DAY_ONE;
                    done_q <= 1'b1;
                end else begin
                    day_q  <= day_q + DAY_ONE;
                end
`ifdef DAY_OF_WEEK_EN
                wd_q <= (wd_q == 3'd6) ? 3'd0 : wd_q + 3'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_day_calendar.sv
// Bench for day_calendar: a Gregorian instance and a %4-only instance share
// stimulus and are compared against a calendar reference model.
module tb_day_calendar;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    day_calendar_if #(.DAY_W(6), .MONTH_W(6), .YEAR_W(7)) bus  ();
    day_calendar_if #(.DAY_W(6), .MONTH_W(6), .YEAR_W(7)) bus0 ();

    day_calendar #(
        .DAY_W(6), .MONTH_W(6), .YEAR_W(7), .BASE_YEAR(2000), .LEAP_MODE(1)
`ifdef DAY_OF_WEEK_EN
        , .RESET_WEEKDAY(6)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    day_calendar #(
        .DAY_W(6), .MONTH_W(6), .YEAR_W(7), .BASE_YEAR(2000), .LEAP_MODE(0)
`ifdef DAY_OF_WEEK_EN
        , .RESET_WEEKDAY(6)
`endif
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    assign bus0.done_hour  = bus.done_hour;
    assign bus0.setup_day  = bus.setup_day;
    assign bus0.set_inc    = bus.set_inc;
    assign bus0.set_dec    = bus.set_dec;
    assign bus0.curr_month = bus.curr_month;
    assign bus0.curr_year  = bus.curr_year;

    int checks = 0;
    int errors = 0;

    // reference model: index 0 = %4-only instance, index 1 = Gregorian instance
    int m_day [2];
    int m_done[2];
    int m_wd  [2];
    int cur_m;
    int cur_y;

    logic [5:0] a_day [2];
    logic       a_done[2];
    logic [4:0] a_dim [2];
    logic       a_err [2];
    logic [2:0] a_wd  [2];

    function automatic int ref_dim(input int m, input int y, input int mode);
        int  yr;
        bit  leap;
        yr = 2000 + y;
        if (m < 1 || m > 12) return 31;
        if (m == 2) begin
            if (mode == 0) leap = (yr % 4 == 0);
            else           leap = (yr % 4 == 0) && ((yr % 100 != 0) || (yr % 400 == 0));
            return leap ? 29 : 28;
        end
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_day[k]  = 1;
            m_done[k] = 0;
            m_wd[k]   = 6;
        end
    endtask

    task automatic model_step(input bit hour, input bit setup, input bit inc, input bit dec);
        int d;
        for (int k = 0; k < 2; k++) begin
            d = ref_dim(cur_m, cur_y, k);
            m_done[k] = 0;
            if (m_day[k] > d) begin
                m_day[k] = d;
            end else if (setup) begin
                if (inc && !dec)      m_day[k] = (m_day[k] == d) ? 1 : m_day[k] + 1;
                else if (dec && !inc) m_day[k] = (m_day[k] == 1) ? d : m_day[k] - 1;
            end else if (hour) begin
                if (m_day[k] == d) begin
                    m_day[k]  = 1;
                    m_done[k] = 1;
                end else begin
                    m_day[k] = m_day[k] + 1;
                end
                m_wd[k] = (m_wd[k] + 1) % 7;
            end
        end
    endtask

    task automatic drive(input bit hour, input bit setup, input bit inc, input bit dec);
        bus.done_hour = hour;
        bus.setup_day = setup;
        bus.set_inc   = inc;
        bus.set_dec   = dec;
        model_step(hour, setup, inc, dec);
        @(posedge clk);
        #1;
        bus.done_hour = 1'b0;
        bus.set_inc   = 1'b0;
        bus.set_dec   = 1'b0;
    endtask

    task automatic set_date(input int m, input int y);
        cur_m = m;
        cur_y = y;
        bus.curr_month = 6'(m);
        bus.curr_year  = 7'(y);
        #1;
    endtask

    task automatic goto_day(input int target);
        for (int i = 0; i < 40 && m_day[1] != target; i++)
            drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hit_reset();
        #1;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic snap();
        a_day[1] = bus.day;   a_done[1] = bus.done_day;  a_dim[1] = bus.dim;  a_err[1] = bus.month_err;
        a_day[0] = bus0.day;  a_done[0] = bus0.done_day; a_dim[0] = bus0.dim; a_err[0] = bus0.month_err;
`ifdef DAY_OF_WEEK_EN
        a_wd[1] = bus.weekday;
        a_wd[0] = bus0.weekday;
`else
        a_wd[1] = 3'd0;
        a_wd[0] = 3'd0;
`endif
    endtask

    task automatic test_reset();
        bus.done_hour = 1'b0; bus.setup_day = 1'b0; bus.set_inc = 1'b0; bus.set_dec = 1'b0;
        set_date(1, 0);
        model_reset();
        #10;
        checks++; if (bus.day !== 6'd1) begin errors++; $display("FAIL reset_day: got %0d expected 1", bus.day); end
        checks++; if (bus.done_day !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done_day); end
`ifdef DAY_OF_WEEK_EN
        checks++; if (bus.weekday !== 3'd6) begin errors++; $display("FAIL reset_weekday: got %0d expected 6", bus.weekday); end
`endif
        rst = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd17) begin errors++; $display("FAIL count_to_17: got %0d expected 17", bus.day); end
        hit_reset();
        checks++; if (bus.day !== 6'd1) begin errors++; $display("FAIL midreset_day: got %0d expected 1", bus.day); end
        checks++; if (bus.done_day !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", bus.done_day); end
`ifdef DAY_OF_WEEK_EN
        checks++; if (bus.weekday !== 3'd6) begin errors++; $display("FAIL midreset_weekday: got %0d expected 6", bus.weekday); end
`endif
        rst = 1'b1;
    endtask

    task automatic test_leap_feb();
        set_date(2, 32);
        checks++; if (bus.dim !== 5'd29) begin errors++; $display("FAIL leap2032_dim: got %0d expected 29", bus.dim); end
        checks++; if (bus0.dim !== 5'd29) begin errors++; $display("FAIL leap2032_dim_mode0: got %0d expected 29", bus0.dim); end
        goto_day(29);
        checks++; if (bus.day !== 6'd29) begin errors++; $display("FAIL leap2032_day29: got %0d expected 29", bus.day); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd1 || bus.done_day !== 1'b1) begin
            errors++; $display("FAIL leap2032_roll: got day %0d done %b expected day 1 done 1", bus.day, bus.done_day); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd1 || bus.done_day !== 1'b0) begin
            errors++; $display("FAIL leap2032_after: got day %0d done %b expected day 1 done 0", bus.day, bus.done_day); end
    endtask

    task automatic test_century();
        set_date(2, 100);
        checks++; if (bus.dim !== 5'd28) begin errors++; $display("FAIL y2100_dim_greg: got %0d expected 28", bus.dim); end
        checks++; if (bus0.dim !== 5'd29) begin errors++; $display("FAIL y2100_dim_mod4: got %0d expected 29", bus0.dim); end
        goto_day(28);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd1 || bus.done_day !== 1'b1) begin
            errors++; $display("FAIL y2100_roll_greg: got day %0d done %b expected day 1 done 1", bus.day, bus.done_day); end
        checks++; if (bus0.day !== 6'd29 || bus0.done_day !== 1'b0) begin
            errors++; $display("FAIL y2100_step_mod4: got day %0d done %b expected day 29 done 0", bus0.day, bus0.done_day); end
        set_date(2, 0);
        checks++; if (bus.dim !== 5'd29 || bus0.dim !== 5'd29) begin
            errors++; $display("FAIL y2000_dim: got %0d/%0d expected 29/29", bus.dim, bus0.dim); end
    endtask

    task automatic test_clamp();
        int wd_exp;
        set_date(1, 0);
        goto_day(31);
        checks++; if (bus.day !== 6'd31) begin errors++; $display("FAIL clamp_setup31: got %0d expected 31", bus.day); end
        wd_exp = m_wd[1];
        set_date(4, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd30 || bus.done_day !== 1'b0) begin
            errors++; $display("FAIL clamp_to30: got day %0d done %b expected day 30 done 0", bus.day, bus.done_day); end
`ifdef DAY_OF_WEEK_EN
        checks++; if (bus.weekday !== 3'(wd_exp)) begin errors++; $display("FAIL clamp_weekday: got %0d expected %0d", bus.weekday, wd_exp); end
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd1 || bus.done_day !== 1'b1) begin
            errors++; $display("FAIL clamp_then_roll: got day %0d done %b expected day 1 done 1", bus.day, bus.done_day); end
    endtask

    task automatic test_setup();
        set_date(1, 0);
        goto_day(1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.day !== 6'd31) begin errors++; $display("FAIL setup_dec_wrap: got %0d expected 31", bus.day); end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.day !== 6'd1) begin errors++; $display("FAIL setup_inc_wrap: got %0d expected 1", bus.day); end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (bus.day !== 6'd1) begin errors++; $display("FAIL setup_both_hold: got %0d expected 1", bus.day); end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd1 || bus.done_day !== 1'b0) begin
            errors++; $display("FAIL setup_ignores_hour: got day %0d done %b expected day 1 done 0", bus.day, bus.done_day); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_date(1, 0);
        goto_day(31);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd1 || bus.done_day !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got day %0d done %b expected day 1 done 1", bus.day, bus.done_day); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd2 || bus.done_day !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got day %0d done %b expected day 2 done 0", bus.day, bus.done_day); end
    endtask

    task automatic test_invalid_month();
        hit_reset();
        rst = 1'b1;
        set_date(0, 0);
        checks++; if (bus.month_err !== 1'b1 || bus.dim !== 5'd31) begin
            errors++; $display("FAIL month0_flags: got err %b dim %0d expected err 1 dim 31", bus.month_err, bus.dim); end
        goto_day(30);
        checks++; if (bus.day !== 6'd30) begin errors++; $display("FAIL month0_day30: got %0d expected 30", bus.day); end
`ifdef DAY_OF_WEEK_EN
        checks++; if (bus.weekday !== 3'd6) begin errors++; $display("FAIL month0_wd_setup: got %0d expected 6", bus.weekday); end
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd31 || bus.done_day !== 1'b0) begin
            errors++; $display("FAIL month0_31: got day %0d done %b expected day 31 done 0", bus.day, bus.done_day); end
`ifdef DAY_OF_WEEK_EN
        checks++; if (bus.weekday !== 3'd0) begin errors++; $display("FAIL month0_wd0: got %0d expected 0", bus.weekday); end
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.day !== 6'd1 || bus.done_day !== 1'b1) begin
            errors++; $display("FAIL month0_roll: got day %0d done %b expected day 1 done 1", bus.day, bus.done_day); end
`ifdef DAY_OF_WEEK_EN
        checks++; if (bus.weekday !== 3'd1) begin errors++; $display("FAIL month0_wd1: got %0d expected 1", bus.weekday); end
`endif
        set_date(13, 0);
        checks++; if (bus.month_err !== 1'b1) begin errors++; $display("FAIL month13_err: got %b expected 1", bus.month_err); end
        set_date(12, 0);
        checks++; if (bus.month_err !== 1'b0) begin errors++; $display("FAIL month12_err: got %b expected 0", bus.month_err); end
    endtask

    task automatic test_random();
        bit setup;
        setup = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) set_date($urandom_range(0, 13), $urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) setup = ~setup;
            drive(1'($urandom_range(0, 1)), setup, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            snap();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (a_day[k] !== 6'(m_day[k]) || a_done[k] !== 1'(m_done[k])) begin
                    errors++;
                    $display("FAIL rand_day mode%0d cycle %0d: got day %0d done %b expected day %0d done %0d",
                             k, n, a_day[k], a_done[k], m_day[k], m_done[k]);
                end
                checks++;
                if (a_dim[k] !== 5'(ref_dim(cur_m, cur_y, k)) || a_err[k] !== 1'(cur_m < 1 || cur_m > 12)) begin
                    errors++;
                    $display("FAIL rand_dim mode%0d cycle %0d: got dim %0d err %b for month %0d year %0d",
                             k, n, a_dim[k], a_err[k], cur_m, cur_y);
                end
`ifdef DAY_OF_WEEK_EN
                checks++;
                if (a_wd[k] !== 3'(m_wd[k])) begin
                    errors++;
                    $display("FAIL rand_weekday mode%0d cycle %0d: got %0d expected %0d", k, n, a_wd[k], m_wd[k]);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_leap_feb();
        test_century();
        test_clamp();
        test_setup();
        test_back_to_back();
        test_invalid_month();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
